// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: FSM state encoding and the
// processor word width.
package seq_pkg;

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RUN, S_HALT} seq_state_t;

  localparam int WORD_W = 10;

endpackage

// File: rtl/tick_gen.sv
// Reloadable down-counter: strobes for one cycle every DIV enabled cycles,
// restart reloads so the first strobe lands DIV cycles after the restart edge.
module tick_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic strobe
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (restart) begin
      cnt <= RELOAD;
    end else if (enable) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

  assign strobe = enable & (cnt == '0);

endmodule

// File: rtl/program_sequencer.sv
// Program RAM, key edge detectors and LOAD/IDLE/RUN/HALT sequencer feeding the
// bus processor. Define PROGRAM_SEQUENCER_SINGLE_STEP_EN for key-driven stepping.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int W        = WORD_W,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic          CLK50MHz,
  input  logic          RSTb,
  input  logic [W-1:0]  SW_DATA,
  input  logic          LOAD_MODE,
  input  logic          LOAD_KEY,
  input  logic          RUN_KEY,
  input  logic          EXT,
  input  logic          DONE,
  output logic [W-1:0]  DATA_OUT,
  output logic          STEP,
  output logic [AW-1:0] PC,
  output logic [AW:0]   PLEN,
  output logic          RUNNING,
  output logic          HALTED,
  output logic          FULL,
  output logic [1:0]    STATE
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  seq_state_t    state, state_n;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] pc, pc_n;
  logic [AW:0]   plen, plen_n;
  logic [AW:0]   pc_inc;
  logic          load_q, run_q;
  logic          load_edge, run_edge;
  logic          tick, tick_en, restart, step, wr_en;

  assign load_edge = LOAD_KEY & ~load_q;
  assign run_edge  = RUN_KEY & ~run_q;
  assign pc_inc    = {1'b0, pc} + {{AW{1'b0}}, EXT};

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk     (CLK50MHz),
    .rst_n   (RSTb),
    .enable  (tick_en),
    .restart (restart),
    .strobe  (tick)
  );

`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
  // A RUN_KEY edge seen while already running steps once on the next cycle.
  logic ss_pend;

  always_ff @(posedge CLK50MHz or negedge RSTb) begin
    if (!RSTb) ss_pend <= 1'b0;
    else       ss_pend <= run_edge & (state == S_RUN) & ~LOAD_MODE;
  end

  assign tick_en = 1'b0;
  assign step    = (ss_pend | tick) & (state == S_RUN) & ~LOAD_MODE;
`else
  assign tick_en = (state == S_RUN);
  assign step    = tick & ~LOAD_MODE;
`endif

  always_ff @(posedge CLK50MHz or negedge RSTb) begin
    if (!RSTb) begin
      state  <= S_LOAD;
      pc     <= '0;
      plen   <= '0;
      load_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      plen   <= plen_n;
      load_q <= LOAD_KEY;
      run_q  <= RUN_KEY;
    end
  end

  // Program contents survive reset and mode changes.
  always_ff @(posedge CLK50MHz) begin
    if (wr_en) mem[plen[AW-1:0]] <= SW_DATA;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    plen_n  = plen;
    wr_en   = 1'b0;
    restart = 1'b0;
    if (LOAD_MODE && (state != S_LOAD)) begin
      state_n = S_LOAD;
      pc_n    = '0;
      if ((state == S_IDLE) || (state == S_HALT)) plen_n = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (!LOAD_MODE) begin
            state_n = S_IDLE;
            pc_n    = '0;
          end else if (load_edge && (plen < DEPTH_L)) begin
            wr_en  = 1'b1;
            plen_n = plen + 1'b1;
          end
        end
        S_IDLE: begin
          if (run_edge) begin
            if (plen != '0) begin
              state_n = S_RUN;
              restart = 1'b1;
            end else begin
              state_n = S_HALT;
            end
          end
        end
        S_RUN: begin
          // Halt is judged on the post-increment PC, one bit wider so a full
          // program can end at PC == DEPTH.
          if (step) begin
            pc_n = pc_inc[AW-1:0];
            if (DONE && (pc_inc == plen)) state_n = S_HALT;
          end
        end
        S_HALT: begin
          if (run_edge) begin
            state_n = S_RUN;
            pc_n    = '0;
            restart = 1'b1;
          end
        end
        default: state_n = S_LOAD;
      endcase
    end
  end

  // Past the last word (mid-immediate) the processor is fed zeros.
  assign DATA_OUT = (((state == S_RUN) || (state == S_HALT)) && ({1'b0, pc} == plen))
                    ? '0 : mem[pc];
  assign STEP     = step;
  assign PC       = pc;
  assign PLEN     = plen;
  assign RUNNING  = (state == S_RUN);
  assign HALTED   = (state == S_HALT);
  assign FULL     = (plen == DEPTH_L);
  assign STATE    = state;

endmodule
